// File: rtl/pcpi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pcpi_pkg
// Brief    : Shared types and constants for the PCPI Z80-side mailbox logic.
// Revision : 1.0 - initial release
// ============================================================================
package pcpi_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD     = 2'd1,
        WAIT_ACK = 2'd2
    } seq_state_e;

    // Z80 I/O port numbers decoded upstream of the sequencer.
    localparam logic [7:0] c_data_port   = 8'h00;
    localparam logic [7:0] c_status_port = 8'h02;

endpackage : pcpi_pkg
`default_nettype wire

// File: rtl/pcpi_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : pcpi_sync_fifo
// Brief    : DEPTH x 8 register FIFO with registered level/full/empty flags.
// Revision : 1.0 - initial release
// ============================================================================
module pcpi_sync_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     clr_z80_data,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               head,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int              c_aw    = $clog2(DEPTH);
    localparam logic [c_aw:0]   c_depth = (c_aw + 1)'(DEPTH);

    logic [7:0]      r_mem [DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_aw:0]   r_level;
    logic [c_aw:0]   w_level_nxt;
    logic            r_full;
    logic            r_empty;
    logic            w_push_ok;
    logic            w_pop_ok;

    // A full FIFO refuses a push even when a pop happens in the same cycle.
    assign w_push_ok = push & ~r_full;
    assign w_pop_ok  = pop & ~r_empty;

    always_comb begin
        w_level_nxt = r_level;
        if (w_push_ok && !w_pop_ok) begin
            w_level_nxt = r_level + 1'b1;
        end else if (!w_push_ok && w_pop_ok) begin
            w_level_nxt = r_level - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge clr_z80_data) begin
        if (clr_z80_data) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == c_depth);
            r_empty <= (w_level_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign level = r_level;
    assign full  = r_full;
    assign empty = r_empty;

endmodule : pcpi_sync_fifo
`default_nettype wire

// File: rtl/pcpi_mbox_seq.sv
`default_nettype none
// ============================================================================
// Module   : pcpi_mbox_seq
// Brief    : Z80->6502 mailbox sequencer: queues port-0 writes and feeds the
//            to-6502 latch one byte per 6502 acknowledge.
// Revision : 1.0 - initial release
// ============================================================================
module pcpi_mbox_seq
    import pcpi_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     clr_z80_data,
    input  logic                     wr_stb,
    input  logic [7:0]               wr_data,
    input  logic                     rd65_ack,
    input  logic                     ovf_clr,
    output logic                     latch_load,
    output logic [7:0]               latch_data,
    output logic                     data_rdy_to6502,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     fifo_full,
    output logic                     overflow
);

    seq_state_e             r_state;
    seq_state_e             w_state_nxt;
    logic                   w_pop;
    logic                   w_push;
    logic [7:0]             w_head;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic [SYNC_STAGES-1:0] r_ack_sync;
    logic                   r_ack_q;
    logic                   r_ack_det;
    logic                   r_latch_load;
    logic                   r_data_rdy;
    logic                   r_overflow;

    assign w_push = wr_stb & ~w_fifo_full;

    pcpi_sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .clr_z80_data (clr_z80_data),
        .push         (w_push),
        .push_data    (wr_data),
        .pop          (w_pop),
        .head         (w_head),
        .level        (fifo_level),
        .full         (w_fifo_full),
        .empty        (w_fifo_empty)
    );

    // The detect pulse is registered so it lands one cycle after the edge
    // reaches the last synchronizer stage.
    always_ff @(posedge clk or posedge clr_z80_data) begin
        if (clr_z80_data) begin
            r_ack_sync <= '0;
            r_ack_q    <= 1'b0;
            r_ack_det  <= 1'b0;
        end else begin
            r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], rd65_ack};
            r_ack_q    <= r_ack_sync[SYNC_STAGES-1];
            r_ack_det  <= r_ack_sync[SYNC_STAGES-1] & ~r_ack_q;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_fifo_empty || w_push) begin
                    w_state_nxt = LOAD;
                end
            end
            LOAD: begin
                w_pop       = 1'b1;
                w_state_nxt = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (r_ack_det) begin
                    w_state_nxt = (!w_fifo_empty || w_push) ? LOAD : IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Strobes are registered from the next state so reset forces them low
    // without decoding a multi-bit state vector.
    always_ff @(posedge clk or posedge clr_z80_data) begin
        if (clr_z80_data) begin
            r_state      <= IDLE;
            r_latch_load <= 1'b0;
            r_data_rdy   <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_latch_load <= (w_state_nxt == LOAD);
            r_data_rdy   <= (w_state_nxt == WAIT_ACK);
            if (wr_stb && w_fifo_full) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign latch_load      = r_latch_load;
    assign latch_data      = r_latch_load ? w_head : 8'h00;
    assign data_rdy_to6502 = r_data_rdy;
    assign fifo_full       = w_fifo_full;
    assign overflow        = r_overflow;

endmodule : pcpi_mbox_seq
`default_nettype wire

// File: tb/tb_pcpi_mbox_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcpi_mbox_seq
// Brief    : Self-checking bench: queue-based reference model plus directed
//            literal expectations for the mailbox sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcpi_mbox_seq;

    localparam int DEPTH       = 4;
    localparam int SYNC_STAGES = 2;
    localparam int LW          = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          clr_z80_data;
    logic          wr_stb;
    logic [7:0]    wr_data;
    logic          rd65_ack;
    logic          ovf_clr;
    logic          latch_load;
    logic [7:0]    latch_data;
    logic          data_rdy_to6502;
    logic [LW-1:0] fifo_level;
    logic          fifo_full;
    logic          overflow;

    int n_cmp = 0;
    int n_bad = 0;

    pcpi_mbox_seq #(
        .DEPTH       (DEPTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk             (clk),
        .clr_z80_data    (clr_z80_data),
        .wr_stb          (wr_stb),
        .wr_data         (wr_data),
        .rd65_ack        (rd65_ack),
        .ovf_clr         (ovf_clr),
        .latch_load      (latch_load),
        .latch_data      (latch_data),
        .data_rdy_to6502 (data_rdy_to6502),
        .fifo_level      (fifo_level),
        .fifo_full       (fifo_full),
        .overflow        (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: queue of pending bytes, latch-loading / waiting flags,
    // and ack detection derived from the history of sampled rd65_ack levels.
    logic [7:0]  mq[$];
    bit          m_load, m_rdy, m_ovf, m_det, m_full, m_acc;
    logic [15:0] ack_hist;

    always @(posedge clk or posedge clr_z80_data) begin
        if (clr_z80_data) begin
            mq.delete();
            m_load   = 1'b0;
            m_rdy    = 1'b0;
            m_ovf    = 1'b0;
            m_det    = 1'b0;
            ack_hist = '0;
        end else begin
            m_full = (mq.size() == DEPTH);
            m_acc  = wr_stb && !m_full;
            if (m_load) void'(mq.pop_front());
            if (m_acc) mq.push_back(wr_data);
            if (wr_stb && m_full) m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
            if (m_load) begin
                m_load = 1'b0;
                m_rdy  = 1'b1;
            end else if (m_rdy) begin
                if (m_det) begin
                    m_rdy  = 1'b0;
                    m_load = (mq.size() > 0);
                end
            end else begin
                m_load = (mq.size() > 0);
            end
            ack_hist = {ack_hist[14:0], rd65_ack};
            m_det    = ack_hist[SYNC_STAGES] & ~ack_hist[SYNC_STAGES+1];
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!clr_z80_data) begin
                chk("mdl_latch_load", 32'(latch_load), 32'(m_load));
                chk("mdl_latch_data", 32'(latch_data), m_load ? 32'(mq[0]) : 32'h0);
                chk("mdl_data_rdy", 32'(data_rdy_to6502), 32'(m_rdy));
                chk("mdl_fifo_level", 32'(fifo_level), 32'(mq.size()));
                chk("mdl_fifo_full", 32'(fifo_full), 32'(mq.size() == DEPTH));
                chk("mdl_overflow", 32'(overflow), 32'(m_ovf));
            end
        end
    end

    task automatic ack_get(input string nm, input logic [7:0] exp);
        bit got = 1'b0;
        rd65_ack = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (latch_load) begin
                got = 1'b1;
                chk(nm, 32'(latch_data), 32'(exp));
                break;
            end
        end
        if (!got) chk({nm, "_timeout"}, 32'(got), 32'd1);
        rd65_ack = 1'b0;
        repeat (SYNC_STAGES + 3) @(negedge clk);
    endtask

    task automatic ack_only();
        rd65_ack = 1'b1;
        repeat (SYNC_STAGES + 3) @(negedge clk);
        rd65_ack = 1'b0;
        repeat (SYNC_STAGES + 3) @(negedge clk);
    endtask

    task automatic write_seq(input logic [7:0] b[$]);
        foreach (b[i]) begin
            wr_stb  = 1'b1;
            wr_data = b[i];
            @(negedge clk);
        end
        wr_stb = 1'b0;
    endtask

    int n;
    int loads;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        clr_z80_data = 1'b1;
        wr_stb = 1'b0; wr_data = 8'h00; rd65_ack = 1'b0; ovf_clr = 1'b0;
        @(negedge clk);
        chk("rst_latch_load", 32'(latch_load), 0);
        chk("rst_latch_data", 32'(latch_data), 0);
        chk("rst_data_rdy", 32'(data_rdy_to6502), 0);
        chk("rst_fifo_level", 32'(fifo_level), 0);
        chk("rst_fifo_full", 32'(fifo_full), 0);
        chk("rst_overflow", 32'(overflow), 0);
        @(negedge clk);
        clr_z80_data = 1'b0;
        repeat (2) @(negedge clk);

        // Single byte
        wr_stb = 1'b1; wr_data = 8'h5A;
        @(negedge clk);
        wr_stb = 1'b0;
        chk("single_load", 32'(latch_load), 1);
        chk("single_data", 32'(latch_data), 32'h5A);
        chk("single_level_n1", 32'(fifo_level), 1);
        @(negedge clk);
        chk("single_rdy", 32'(data_rdy_to6502), 1);
        chk("single_level_n2", 32'(fifo_level), 0);
        rd65_ack = 1'b1;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (!data_rdy_to6502) begin n = i; break; end
        end
        chk("single_ack_latency", 32'(n), 32'(SYNC_STAGES + 2));
        rd65_ack = 1'b0;
        repeat (SYNC_STAGES + 3) @(negedge clk);

        // Burst with overflow
        wr_stb = 1'b1; wr_data = 8'h01;
        @(negedge clk);
        chk("burst_first_load", 32'(latch_load), 1);
        chk("burst_first_data", 32'(latch_data), 32'h01);
        for (int b = 2; b <= 6; b++) begin
            wr_data = 8'(b);
            @(negedge clk);
        end
        wr_stb = 1'b0;
        chk("burst_full", 32'(fifo_full), 1);
        chk("burst_level", 32'(fifo_level), 32'(DEPTH));
        chk("burst_overflow", 32'(overflow), 1);

        // Overflow clear
        wr_stb = 1'b1; wr_data = 8'h07; ovf_clr = 1'b1;
        @(negedge clk);
        wr_stb = 1'b0; ovf_clr = 1'b0;
        chk("ovfclr_with_drop", 32'(overflow), 1);
        chk("ovfclr_level", 32'(fifo_level), 32'(DEPTH));
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("ovfclr_alone", 32'(overflow), 0);

        ack_get("burst_ack1", 8'h02);
        ack_get("burst_ack2", 8'h03);
        ack_get("burst_ack3", 8'h04);
        ack_get("burst_ack4", 8'h05);
        chk("burst_drained", 32'(fifo_level), 0);
        chk("burst_last_rdy", 32'(data_rdy_to6502), 1);
        ack_only();
        chk("burst_idle_rdy", 32'(data_rdy_to6502), 0);

        // Push in the cycle the ack is detected
        write_seq('{8'hA1, 8'hA2, 8'hA3});
        chk("same_level_pre", 32'(fifo_level), 2);
        rd65_ack = 1'b1;
        repeat (SYNC_STAGES + 1) @(negedge clk);
        wr_stb = 1'b1; wr_data = 8'h77;
        @(negedge clk);
        wr_stb = 1'b0; rd65_ack = 1'b0;
        chk("same_load", 32'(latch_load), 1);
        chk("same_old_head", 32'(latch_data), 32'hA2);
        @(negedge clk);
        chk("same_level_post", 32'(fifo_level), 2);
        repeat (SYNC_STAGES + 3) @(negedge clk);
        ack_get("same_next", 8'hA3);
        ack_get("same_last", 8'h77);
        ack_only();

        // Ack while idle is ignored
        rd65_ack = 1'b1;
        repeat (2) @(negedge clk);
        rd65_ack = 1'b0;
        loads = 0;
        repeat (SYNC_STAGES + 5) begin
            @(negedge clk);
            if (latch_load) loads++;
        end
        chk("idle_ack_no_load", 32'(loads), 0);
        wr_stb = 1'b1; wr_data = 8'h33;
        @(negedge clk);
        wr_stb = 1'b0;
        chk("idle_write_load", 32'(latch_load), 1);
        chk("idle_write_data", 32'(latch_data), 32'h33);
        repeat (10) @(negedge clk);
        chk("idle_rdy_held", 32'(data_rdy_to6502), 1);
        ack_only();

        // Reset mid-operation
        write_seq('{8'hB1, 8'hB2, 8'hB3, 8'hB4});
        chk("rstmid_level", 32'(fifo_level), 3);
        chk("rstmid_rdy", 32'(data_rdy_to6502), 1);
        #2 clr_z80_data = 1'b1;
        #1;
        chk("rstmid_latch_load", 32'(latch_load), 0);
        chk("rstmid_latch_data", 32'(latch_data), 0);
        chk("rstmid_data_rdy", 32'(data_rdy_to6502), 0);
        chk("rstmid_fifo_level", 32'(fifo_level), 0);
        chk("rstmid_fifo_full", 32'(fifo_full), 0);
        chk("rstmid_overflow", 32'(overflow), 0);
        repeat (2) @(negedge clk);
        clr_z80_data = 1'b0;
        loads = 0;
        repeat (10) begin
            @(negedge clk);
            if (latch_load) loads++;
        end
        chk("rstmid_no_load", 32'(loads), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_pcpi_mbox_seq
`default_nettype wire
